// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute request, memory port B, writeback and status signals of the load/store unit
interface load_store_unit_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic [1:0]       mem_op;
  logic [1:0]       mem_size;
  logic             mem_ready;
  logic [31:0]      mem_dout;
  logic             mem_read_valid;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             misalign_err;
  logic             busy;
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
           mem_ready, mem_dout, mem_read_valid,
    output req_ready, mem_en, mem_we, mem_addr, mem_din, mem_op, mem_size,
           wb_valid, wb_data, wb_tag, misalign_err, busy
  );
  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
           mem_ready, mem_dout, mem_read_valid,
    input  req_ready, mem_en, mem_we, mem_addr, mem_din, mem_op, mem_size,
           wb_valid, wb_data, wb_tag, misalign_err, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: clk/reset plus bus (req_* in, mem_* port B, wb_* out, misalign_err, busy); issues aligned word requests, queues DEPTH loads in order, extends returns; define LSU_MISALIGN_TRAP_EN to trap misaligned requests instead of force-aligning
module load_store_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic [1:0]       size;
    logic             uns;
  } ent_t;
  ent_t q_mem [DEPTH];
  ent_t head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full, accept, issue, push, pop;
  logic [1:0] off, eff_off, op_d;
  logic [3:0] we_d;
  logic [31:0] rep, din_d, shifted, wb_data_d;
  logic mem_en_q;
  logic [1:0] mem_op_q, mem_size_q;
  logic [3:0] mem_we_q;
  logic [31:0] mem_addr_q, mem_din_q, wb_data_q;
  logic wb_valid_q;
  logic [TAG_W-1:0] wb_tag_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis, err_q;
  assign mis = (bus.req_size == 2'b01 & off[0]) | (bus.req_size[1] & |off);
  assign issue = accept & ~mis;
  assign bus.misalign_err = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else err_q <= accept & mis;
`else
  assign issue = accept;
  assign bus.misalign_err = 1'b0;
`endif
  assign full = count_q == CW'(DEPTH);
  assign bus.req_ready = ~reset & bus.mem_ready & (~full | bus.req_store);
  assign accept = bus.req_valid & bus.req_ready;
  assign off = bus.req_addr[1:0];
  always_comb begin
    eff_off = bus.req_size[1] ? 2'b00 : bus.req_size[0] ? {off[1], 1'b0} : off;
    we_d = ~bus.req_store ? 4'b0000 : bus.req_size[1] ? 4'b1111 : (bus.req_size[0] ? 4'b0011 : 4'b0001) << eff_off;
    rep = bus.req_size[1] ? bus.req_wdata : bus.req_size[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
    din_d = bus.req_store ? rep << {eff_off, 3'b000} : 32'd0;
    op_d = bus.req_store ? 2'b10 : 2'b01;
    push = issue & ~bus.req_store;
    pop = bus.mem_read_valid & (count_q != '0);
    head = q_mem[rd_ptr_q];
    shifted = bus.mem_dout >> {head.off, 3'b000};
    wb_data_d = head.size[1] ? shifted
              : head.size[0] ? {{16{~head.uns & shifted[15]}}, shifted[15:0]}
              : {{24{~head.uns & shifted[7]}}, shifted[7:0]};
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_op_q   <= 2'b00;
      mem_size_q <= 2'b00;
      mem_we_q   <= 4'b0000;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_tag_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_en_q   <= issue;
      mem_op_q   <= issue ? op_d : 2'b00;
      mem_size_q <= issue ? bus.req_size : 2'b00;
      mem_we_q   <= issue ? we_d : 4'b0000;
      mem_addr_q <= issue ? {bus.req_addr[31:2], 2'b00} : 32'd0;
      mem_din_q  <= issue ? din_d : 32'd0;
      wb_valid_q <= pop;
      wb_data_q  <= pop ? wb_data_d : 32'd0;
      wb_tag_q   <= pop ? head.tag : '0;
    end
  always_ff @(posedge clk)
    if (push) q_mem[wr_ptr_q] <= '{tag: bus.req_tag, off: eff_off, size: bus.req_size, uns: bus.req_unsigned};
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_op   = mem_op_q;
  assign bus.mem_size = mem_size_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_tag   = wb_tag_q;
  assign bus.busy     = count_q != '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit covering stores, extended loads, full queue, wrap, misalignment and reset
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  load_store_unit_if #(.TAG_W(5)) bus ();
  load_store_unit #(.DEPTH(4), .TAG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
  } mem_t;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } wb_t;
  mem_t exp_mem[$];
  wb_t exp_wb[$];
  logic [31:0] dout_q[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask
  mem_t em;
  wb_t ew;
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (exp_mem.size() == 0) chk("mem_unexp", 32'(bus.mem_en), 32'd0);
      else begin
        em = exp_mem.pop_front();
        chk("mem_op", 32'(bus.mem_op), 32'(em.op));
        chk("mem_we", 32'(bus.mem_we), 32'(em.we));
        chk("mem_addr", bus.mem_addr, em.addr);
        chk("mem_size", 32'(bus.mem_size), 32'(em.size));
        if (em.op == 2'b10) chk("mem_din", bus.mem_din, em.din);
      end
    end
    if (bus.wb_valid) begin
      if (exp_wb.size() == 0) chk("wb_unexp", 32'(bus.wb_valid), 32'd0);
      else begin
        ew = exp_wb.pop_front();
        chk("wb_data", bus.wb_data, ew.data);
        chk("wb_tag", 32'(bus.wb_tag), 32'(ew.tag));
      end
    end
  end
  task automatic send(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] tag, input logic [3:0] e_we, input logic [31:0] e_din, input logic [31:0] dout,
                      input logic [31:0] e_wb, input bit exp_issue, input bit exp_wb_en);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_tag = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    if (!ok) chk("req_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (ok && exp_issue) exp_mem.push_back('{st ? 2'b10 : 2'b01, e_we, {addr[31:2], 2'b00}, e_din, sz});
    if (ok && exp_issue && !st) begin
      dout_q.push_back(dout);
      if (exp_wb_en) exp_wb.push_back('{e_wb, tag});
    end
  endtask
  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] e_we, input logic [31:0] e_din);
    send(1'b1, sz, 1'b0, addr, wdata, 5'd0, e_we, e_din, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask
  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr, input logic [4:0] tag, input logic [31:0] dout, input logic [31:0] e_wb);
    send(1'b0, sz, uns, addr, 32'd0, tag, 4'b0000, 32'd0, dout, e_wb, 1'b1, 1'b1);
  endtask
  task automatic ret();
    bus.mem_read_valid = 1'b1;
    bus.mem_dout = dout_q.size() != 0 ? dout_q.pop_front() : 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    bus.mem_read_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_tag = 5'd0;
    bus.mem_ready = 1'b1;
    bus.mem_dout = 32'd0;
    bus.mem_read_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    store(2'b00, 32'h8000_0003, 32'h0000_00AB, 4'b1000, 32'hAB00_0000);
    store(2'b00, 32'h8000_0001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A00);
    store(2'b01, 32'h8000_0002, 32'h0000_1234, 4'b1100, 32'h1234_0000);
    store(2'b10, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    load(2'b01, 1'b0, 32'h8000_0002, 5'd7, 32'h8123_4567, 32'hFFFF_8123);
    ret();
    load(2'b01, 1'b1, 32'h8000_0002, 5'd7, 32'h8123_4567, 32'h0000_8123);
    ret();
    load(2'b00, 1'b0, 32'h8000_0001, 5'd3, 32'h0000_9A00, 32'hFFFF_FF9A);
    ret();
    load(2'b00, 1'b1, 32'h8000_0003, 5'd4, 32'h9A00_0000, 32'h0000_009A);
    ret();
    load(2'b11, 1'b0, 32'h8000_0008, 5'd9, 32'h1234_5678, 32'h1234_5678);
    ret();
    for (int t = 1; t <= 4; t++)
      load(2'b10, 1'b0, 32'h8000_0010, 5'(t), 32'(t) * 32'h0101_0101, 32'(t) * 32'h0101_0101);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b0;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h8000_0020;
    bus.req_wdata = 32'h0000_0055;
    bus.req_tag = 5'd5;
    @(negedge clk);
    chk("full_ld_ready", 32'(bus.req_ready), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    bus.req_store = 1'b1;
    #1;
    chk("full_st_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_mem.push_back('{2'b10, 4'b1111, 32'h8000_0020, 32'h0000_0055, 2'b10});
    ret();
    fork
      load(2'b10, 1'b0, 32'h8000_0014, 5'd5, 32'h5555_5555, 32'h5555_5555);
      ret();
    join
    load(2'b10, 1'b0, 32'h8000_0018, 5'd6, 32'h6666_6666, 32'h6666_6666);
    @(negedge clk);
    chk("refull_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    repeat (4) ret();
    repeat (2) @(negedge clk);
    chk("drain_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'd0, 5'd8, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("mis_err_pulse", 32'(bus.misalign_err), 32'd0);
    @(posedge clk);
    #1;
`else
    load(2'b10, 1'b0, 32'h8000_0001, 5'd8, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(negedge clk);
    chk("mis_err_off", 32'(bus.misalign_err), 32'd0);
    @(posedge clk);
    #1;
    ret();
    store(2'b01, 32'h8000_0003, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
`endif
    send(1'b0, 2'b10, 1'b0, 32'h8000_0030, 32'd0, 5'd10, 4'b0000, 32'd0, 32'h1010_1010, 32'd0, 1'b1, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h8000_0034, 32'd0, 5'd11, 4'b0000, 32'd0, 32'h1111_1111, 32'd0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    exp_mem.delete();
    dout_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ret();
    @(negedge clk);
    chk("late_wb", 32'(bus.wb_valid), 32'd0);
    chk("late_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("mem_left", 32'(exp_mem.size()), 32'd0);
    chk("wb_left", 32'(exp_wb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
